// File: rtl/sysid_info_pkg.sv
// rtl/sysid_info_pkg.sv - shared constants for the system-ID info register block
//
// Purpose: word addresses of the register map, CTRL bit positions and the
// CAPS word layout used by sysid_info_regs and its uptime counter.
// Ports: none (package).

package sysid_info_pkg;

  // Word addresses of the register map
  localparam int unsigned ADR_ID        = 0;
  localparam int unsigned ADR_TS        = 1;
  localparam int unsigned ADR_CAPS      = 2;
  localparam int unsigned ADR_SCRATCH   = 3;
  localparam int unsigned ADR_UP_LO     = 4;
  localparam int unsigned ADR_UP_HI     = 5;
  localparam int unsigned ADR_CTRL      = 6;
  localparam int unsigned ADR_INFO_BASE = 8;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_CLR  = 1;
  localparam int unsigned CTRL_WRAP = 8;

  localparam logic [7:0] CAPS_VERSION = 8'h01;

  // Live CTRL state; clear is write-only and has no storage
  typedef struct packed {
    logic wrap;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] caps_word(input int unsigned addr_w,
                                            input int unsigned num_info);
    caps_word = {CAPS_VERSION, 8'h00, addr_w[7:0], num_info[7:0]};
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// rtl/sysid_uptime_counter.sv - 64-bit uptime counter with hi-word snapshot shadow
//
// Purpose: free-running 64-bit counter with enable and synchronous clear.
// A snapshot strobe latches the upper word so software can read lo then hi
// coherently.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   en_i       count enable
//   clr_i      clear counter to 0 (wins over increment)
//   snap_i     capture count[63:32] into the shadow on this edge
//   count_lo_o live count[31:0]
//   shadow_o   captured upper word
//   wrap_o     high in the cycle whose edge rolls the counter over to 0

module sysid_uptime_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        snap_i,
  output logic [31:0] count_lo_o,
  output logic [31:0] shadow_o,
  output logic        wrap_o
);

  logic [63:0] count_q, count_d;
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    count_d  = count_q;
    shadow_d = shadow_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 64'd1;
    end
    // Shadow samples the pre-edge value, matching the lo word returned by the same read
    if (snap_i) begin
      shadow_d = count_q[63:32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
    end
  end

  assign wrap_o     = en_i & ~clr_i & (&count_q);
  assign count_lo_o = count_q[31:0];
  assign shadow_o   = shadow_q;

endmodule

// File: rtl/sysid_info_regs.sv
// rtl/sysid_info_regs.sv - Avalon-MM identity / build-info / uptime register slave
//
// Purpose: read-latency-1 register block returning system ID, build timestamp,
// capabilities, a scratch word, a 64-bit uptime counter (coherent lo/hi),
// a control register and NUM_INFO build-info words. Never stalls.
// Ports:
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   address        word address
//   read           read strobe
//   write          write strobe (dropped when read is also high)
//   writedata      write data
//   byteenable     write byte lanes
//   readdata       registered read data, holds between reads
//   readdatavalid  one-cycle pulse per read

module sysid_info_regs
  import sysid_info_pkg::*;
#(
  parameter logic [31:0]            SYSTEM_ID  = 32'hDECA_0001,
  parameter logic [31:0]            TIMESTAMP  = 32'h0000_0000,
  parameter int unsigned            ADDR_W     = 4,
  parameter int unsigned            NUM_INFO   = 4,
  parameter logic [32*NUM_INFO-1:0] INFO_WORDS = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  logic [31:0] addr;
  logic        wr_en, ctrl_wr, clr, snap, wrap_pulse;
  logic [31:0] scratch_q, scratch_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q;
  logic [31:0] up_lo, up_shadow, ctrl_rd;

  assign addr    = 32'(address);
  assign wr_en   = write & ~read;
  assign ctrl_wr = wr_en && (addr == ADR_CTRL);
  assign clr     = ctrl_wr & writedata[CTRL_CLR];
  assign snap    = read && (addr == ADR_UP_LO);

  sysid_uptime_counter u_uptime (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .en_i       (ctrl_q.en),
    .clr_i      (clr),
    .snap_i     (snap),
    .count_lo_o (up_lo),
    .shadow_o   (up_shadow),
    .wrap_o     (wrap_pulse)
  );

  always_comb begin
    scratch_d = scratch_q;
    if (wr_en && (addr == ADR_SCRATCH)) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  // A rollover on the same edge as a W1C keeps the flag set
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d.en = writedata[CTRL_EN];
      if (writedata[CTRL_WRAP]) ctrl_d.wrap = 1'b0;
    end
    if (wrap_pulse) ctrl_d.wrap = 1'b1;
  end

  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[CTRL_EN]   = ctrl_q.en;
    ctrl_rd[CTRL_WRAP] = ctrl_q.wrap;
  end

  always_comb begin
    readdata_d = '0;
    case (addr)
      ADR_ID:      readdata_d = SYSTEM_ID;
      ADR_TS:      readdata_d = TIMESTAMP;
      ADR_CAPS:    readdata_d = caps_word(ADDR_W, NUM_INFO);
      ADR_SCRATCH: readdata_d = scratch_q;
      ADR_UP_LO:   readdata_d = up_lo;
      ADR_UP_HI:   readdata_d = up_shadow;
      ADR_CTRL:    readdata_d = ctrl_rd;
      default: begin
        for (int i = 0; i < int'(NUM_INFO); i++) begin
          if (addr == ADR_INFO_BASE + 32'(i)) readdata_d = INFO_WORDS[32*i +: 32];
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      scratch_q  <= '0;
      ctrl_q     <= '{wrap: 1'b0, en: 1'b1};
    end else begin
      rvalid_q  <= read;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      if (read) readdata_q <= readdata_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// tb/tb_sysid_info_regs.sv - self-checking bench for sysid_info_regs

module tb_sysid_info_regs;

  localparam logic [31:0]  SYS_ID = 32'hDECA_0001;
  localparam logic [31:0]  TS     = 32'h6543_2100;
  localparam logic [127:0] INFO   = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  // Reference state
  logic [63:0] m_cnt = '0;
  logic [31:0] m_shadow = '0, m_scr = '0, m_rdata = '0;
  logic        m_rvalid = 1'b0, m_en = 1'b1, m_wrap = 1'b0;
  logic [31:0] info_tbl [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

  sysid_info_regs #(
    .SYSTEM_ID  (SYS_ID),
    .TIMESTAMP  (TS),
    .ADDR_W     (4),
    .NUM_INFO   (4),
    .INFO_WORDS (INFO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0: return SYS_ID;
      1: return TS;
      2: return {8'h01, 8'h00, 8'd4, 8'd4};
      3: return m_scr;
      4: return m_cnt[31:0];
      5: return m_shadow;
      6: return {23'd0, m_wrap, 7'd0, m_en};
      8, 9, 10, 11: return info_tbl[a-8];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic wr, clr, rolled;
    if (!reset_n) begin
      m_rdata = '0; m_rvalid = 1'b0; m_scr = '0; m_cnt = '0;
      m_shadow = '0; m_en = 1'b1; m_wrap = 1'b0;
      return;
    end
    wr = write && !read;
    rolled = 1'b0;
    m_rvalid = read;
    if (read) begin
      m_rdata = m_read(int'(address));
      if (address == 4'd4) m_shadow = m_cnt[63:32];
    end
    if (wr && address == 4'd3)
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) m_scr[8*b +: 8] = writedata[8*b +: 8];
    clr = wr && address == 4'd6 && writedata[1];
    if (clr) m_cnt = '0;
    else if (m_en) begin
      rolled = (m_cnt == '1);
      m_cnt = m_cnt + 64'd1;
    end
    if (wr && address == 4'd6) begin
      m_en = writedata[0];
      if (writedata[8]) m_wrap = 1'b0;
    end
    if (rolled) m_wrap = 1'b1;
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (cmp_on) begin
      check("rvalid", {31'd0, readdatavalid}, {31'd0, m_rvalid});
      check("rdata", readdata, m_rdata);
    end
  end

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    read = 1'b1; address = a;
    @(negedge clock);
    read = 1'b0;
    d = readdata;
    check("rv_pulse", {31'd0, readdatavalid}, 32'd1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; address = a; writedata = d; byteenable = be;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load_counter(input logic [63:0] v);
    force dut.u_uptime.count_q = v;
    m_cnt = v;
    #1;
    release dut.u_uptime.count_q;
  endtask

  logic [31:0] d;

  initial begin
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    cmp_on = 1'b1;
    check("reset_rvalid", {31'd0, readdatavalid}, 32'd0);
    check("reset_rdata", readdata, 32'd0);

    // Back-to-back identity reads
    do_read(4'd0, d); check("id", d, 32'hDECA_0001);
    do_read(4'd1, d); check("timestamp", d, 32'h6543_2100);
    do_read(4'd2, d); check("caps", d, 32'h0100_0404);
    idle(1);

    // Byte-enabled scratch, ignored RO write
    do_write(4'd3, 32'hA5A5_A5A5, 4'b0101);
    do_read(4'd3, d); check("scratch_be", d, 32'h00A5_00A5);
    do_write(4'd0, 32'hFFFF_FFFF, 4'hF);
    do_read(4'd0, d); check("id_ro", d, 32'hDECA_0001);

    // Coherent snapshot across a carry into the upper word
    load_counter(64'h0000_0001_FFFF_FFFE);
    do_read(4'd4, d); check("snap_lo", d, 32'hFFFF_FFFE);
    idle(1);
    do_read(4'd5, d); check("snap_hi", d, 32'h0000_0001);
    idle(3);
    do_read(4'd5, d); check("shadow_stale", d, 32'h0000_0001);

    // Freeze, then clear and re-enable
    do_write(4'd6, 32'h0, 4'hF);
    idle(10);
    do_read(4'd4, d);
    do_read(4'd4, d);
    do_read(4'd6, d); check("ctrl_off", d, 32'h0);
    do_write(4'd6, 32'h3, 4'hF);
    do_read(4'd4, d); check("clear_lo", d, 32'd0);
    idle(4);
    do_read(4'd4, d); check("count_5", d, 32'd5);

    // Rollover sets wrap; W1C clears it
    load_counter(64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    do_read(4'd6, d); check("wrap_set", d, 32'h0000_0101);
    do_write(4'd6, 32'h101, 4'hF);
    do_read(4'd6, d); check("wrap_clr", d, 32'h0000_0001);

    // Build-info words, reserved and unmapped
    for (int i = 0; i < 4; i++) begin
      do_read(4'(8 + i), d);
      check("info", d, info_tbl[i]);
    end
    do_read(4'd7, d);  check("rsvd", d, 32'd0);
    do_read(4'd12, d); check("unmapped12", d, 32'd0);
    do_read(4'd15, d); check("unmapped15", d, 32'd0);

    // Simultaneous read and write: write dropped
    read = 1'b1; write = 1'b1; address = 4'd3; writedata = 32'h1234_5678; byteenable = 4'hF;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    check("rw_old", readdata, 32'h00A5_00A5);
    do_read(4'd3, d); check("rw_unchanged", d, 32'h00A5_00A5);

    // Reset with a read pending
    read = 1'b1; address = 4'd0;
    @(posedge clock);
    #2;
    read = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_mid_rvalid", {31'd0, readdatavalid}, 32'd0);
    check("rst_mid_rdata", readdata, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    do_read(4'd3, d); check("scratch_after_rst", d, 32'd0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
